// File: rtl/row_clear_seq.sv
// In-place line-clear engine: drops full rows, shifts survivors down, zero-fills the top.
// Optional ROW_CLEAR_SCORE_EN adds a registered score_inc output.
module row_clear_seq #(
  parameter int ROWS = 22,
  parameter int COLS = 10,
  parameter int AW   = $clog2(ROWS),
  parameter int CW   = $clog2(ROWS + 1)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic [ROWS-1:0] full_rows,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   clear_count,
  output logic [AW-1:0]   rd_addr,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [COLS-1:0] wr_data
`ifdef ROW_CLEAR_SCORE_EN
  ,
  output logic [10:0]     score_inc
`endif
);

  typedef enum logic [2:0] {
    IDLE, SCAN, WRITE, FILL, DONE
  } state_t;

  localparam logic [AW-1:0] LAST  = AW'(ROWS - 1);
  localparam logic [CW-1:0] WLAST = CW'(ROWS - 1);

  state_t          state;
  logic [ROWS-1:0] mask;
  logic [AW-1:0]   r;
  logic [AW-1:0]   rd_q;
  logic [CW-1:0]   w;
  logic [CW-1:0]   cnt;

  logic          at_last;
  logic          in_place;
  logic          enter_done;
  logic [CW-1:0] w_inc;

  assign at_last  = (r == LAST);
  assign in_place = (CW'(r) == w);
  assign w_inc    = w + 1'b1;

  // Only an in-place top row or the last fill write can end the run.
  assign enter_done =
    (state == SCAN && !mask[r] && in_place && at_last) ||
    (state == FILL && w == WLAST);

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign wr_en   = (state == WRITE) || (state == FILL);
  assign wr_addr = w[AW-1:0];
  assign wr_data = (state == WRITE) ? rd_data : '0;
  assign rd_addr = (state == SCAN) ? r : rd_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      mask  <= '0;
      r     <= '0;
      w     <= '0;
      cnt   <= '0;
      rd_q  <= '0;
    end else begin
      rd_q <= rd_addr;
      unique case (state)
        IDLE: if (start) begin
          mask  <= full_rows;
          r     <= '0;
          w     <= '0;
          cnt   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (mask[r]) begin
            cnt <= cnt + 1'b1;
            r   <= r + 1'b1;
            if (at_last) state <= FILL;
          end else if (in_place) begin
            r <= r + 1'b1;
            w <= w_inc;
            if (at_last) state <= DONE;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          r     <= r + 1'b1;
          w     <= w_inc;
          state <= at_last ? FILL : SCAN;
        end
        FILL: begin
          w <= w_inc;
          if (enter_done) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROW_CLEAR_SCORE_EN
  function automatic logic [10:0] score_of(input logic [CW-1:0] c);
    if (c == '0)            return 11'd0;
    else if (c == CW'(1))   return 11'd40;
    else if (c == CW'(2))   return 11'd100;
    else if (c == CW'(3))   return 11'd300;
    else                    return 11'd1200;
  endfunction
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clear_count <= '0;
`ifdef ROW_CLEAR_SCORE_EN
      score_inc   <= '0;
`endif
    end else if (enter_done) begin
      clear_count <= cnt;
`ifdef ROW_CLEAR_SCORE_EN
      score_inc   <= score_of(cnt);
`endif
    end
  end

endmodule

// File: tb/tb_row_clear_seq.sv
// Bench for row_clear_seq: board RAM model plus queue-based compaction reference.
// Directed and random masks, spurious starts, and reset during a copy.
module tb_row_clear_seq;

  localparam int ROWS = 22;
  localparam int COLS = 10;
  localparam int AW   = 5;
  localparam int CW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ROWS-1:0] full_rows;
  logic            busy;
  logic            done;
  logic [CW-1:0]   clear_count;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;
`ifdef ROW_CLEAR_SCORE_EN
  logic [10:0]     score_inc;
`endif

  int tests = 0;
  int fails = 0;

  logic [COLS-1:0] board[ROWS];
  logic [COLS-1:0] img[ROWS];
  logic            load = 1'b0;

  always #5 clk = ~clk;

  row_clear_seq #(.ROWS(ROWS), .COLS(COLS)) dut (
    .Clk(clk),
    .Reset(rst),
    .start(start),
    .full_rows(full_rows),
    .busy(busy),
    .done(done),
    .clear_count(clear_count),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
`ifdef ROW_CLEAR_SCORE_EN
    ,
    .score_inc(score_inc)
`endif
  );

  // Synchronous board RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < ROWS; i++) board[i] <= img[i];
    end else if (wr_en) begin
      board[wr_addr] <= wr_data;
    end
    rd_data <= board[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int score_ref(input int c);
    if (c == 0) return 0;
    if (c == 1) return 40;
    if (c == 2) return 100;
    if (c == 3) return 300;
    return 1200;
  endfunction

  task automatic load_img();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input string tag, input logic [ROWS-1:0] m,
                     input bit noise);
    logic [COLS-1:0] q[$];
    int pc, low, copies, exp_cyc, cyc, nwr, busy_bad, bad;
    bit got;
    pc  = 0;
    low = ROWS;
    for (int i = 0; i < ROWS; i++) begin
      if (m[i]) begin
        pc++;
        if (low == ROWS) low = i;
      end else begin
        q.push_back(img[i]);
      end
    end
    while (q.size() < ROWS) q.push_back('0);
    copies  = ROWS - pc - low;
    exp_cyc = 1 + pc + low + 2 * copies + pc;

    @(negedge clk);
    full_rows = m;
    start     = 1'b1;
    got = 1'b0; cyc = 0; nwr = 0; busy_bad = 0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) full_rows = ROWS'($urandom);
      if (wr_en) nwr++;
      if (!busy) busy_bad++;
      if (done) begin
        got   = 1'b1;
        cyc   = k;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "/done_cyc"}, cyc, exp_cyc);
    check({tag, "/writes"}, nwr, copies + pc);
    check({tag, "/busy"}, busy_bad, 0);
    check({tag, "/count"}, 32'(clear_count), pc);
`ifdef ROW_CLEAR_SCORE_EN
    check({tag, "/score"}, 32'(score_inc), score_ref(pc));
`endif
    @(negedge clk);
    check({tag, "/idle"}, {31'd0, busy}, 0);
    check({tag, "/count_hold"}, 32'(clear_count), pc);
    bad = 0;
    for (int i = 0; i < ROWS; i++) if (board[i] !== q[i]) bad++;
    check({tag, "/board_bad_rows"}, bad, 0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    full_rows = '0;
    for (int k = 0; k < ROWS; k++) img[k] = COLS'(k);
    repeat (2) @(negedge clk);
    check("rst/busy", {31'd0, busy}, 0);
    check("rst/done", {31'd0, done}, 0);
    check("rst/wr_en", {31'd0, wr_en}, 0);
    check("rst/count", 32'(clear_count), 0);
    check("rst/rd_addr", 32'(rd_addr), 0);
    check("rst/wr_addr", 32'(wr_addr), 0);
    check("rst/wr_data", 32'(wr_data), 0);
    rst = 1'b0;

    load_img();
    run("none", 22'h000000, 1'b0);
    load_img();
    run("bottom", 22'h000001, 1'b0);
    load_img();
    run("rows3_5", 22'h000028, 1'b0);
    load_img();
    run("all", 22'h3FFFFF, 1'b0);
    load_img();
    run("top", 22'h200000, 1'b0);
    load_img();
    run("noise3_5", 22'h000028, 1'b1);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < ROWS; k++) img[k] = COLS'($urandom);
      load_img();
      run("rand", ROWS'($urandom & $urandom), t == 5);
    end

    // Reset during a row copy, then a clean rerun.
    for (int k = 0; k < ROWS; k++) img[k] = COLS'(k);
    load_img();
    @(negedge clk);
    full_rows = 22'h000001;
    start     = 1'b1;
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (!wr_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrst/reached_write", {31'd0, wr_en}, 1);
    rst = 1'b1;
    #1;
    check("midrst/wr_en", {31'd0, wr_en}, 0);
    check("midrst/busy", {31'd0, busy}, 0);
    check("midrst/count", 32'(clear_count), 0);
    @(negedge clk);
    rst = 1'b0;
    load_img();
    run("after_rst", 22'h000001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/row_clear_seq.md
Name: row_clear_seq

Overview:
- Sequential line-clear engine for the Tetris playfield.
- On `start`, compacts the board held in the external board RAM: removes every row flagged full, moves the rows above down, and zero-fills the vacated top rows.
- Generalises the fixed 22-row combinational shift mask to a parametrised, multi-row, in-place clear with a start/busy/done handshake.
- Sits between the row-full detector and the board RAM write port.

Parameters:
- ROWS, 22, number of playfield rows; row 0 is the bottom, row ROWS-1 is the top.
- COLS, 10, cells per row (board RAM word width).
- AW, $clog2(ROWS), row-address width.
- CW, $clog2(ROWS+1), clear-count width.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- full_rows  input  ROWS  bit r = row r is full; captured on an accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the DONE state.
- clear_count  output  CW  number of rows removed; updated on entering DONE; holds until the next accepted start.
- rd_addr  output  AW  board RAM read address.
- rd_data  input  COLS  board RAM read data; synchronous RAM, 1-cycle latency.
- wr_en  output  1  board RAM write strobe.
- wr_addr  output  AW  board RAM write address.
- wr_data  output  COLS  board RAM write data.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, wr_en=0.
  - clear_count=0, rd_addr=0, wr_addr=0, wr_data=0.
  - Internal pointers r=0, w=0; captured mask cleared.
  - A partially compacted board is left as-is; no recovery is attempted.
- Outputs are Moore: functions of registered state and pointers only.
- States: IDLE, SCAN, WRITE, FILL, DONE.
- IDLE:
  - start=1 captures full_rows into mask and sets r=0, w=0, cnt=0, then goes to SCAN.
  - start while not in IDLE is ignored.
- SCAN (handles row r):
  - mask[r]=1: cnt++, r++ (skip, 1 cycle).
  - mask[r]=0 and w==r: r++, w++ (row already in place, 1 cycle, no RAM access).
  - mask[r]=0 and w!=r: drive rd_addr=r, go to WRITE.
  - When the handled row is r==ROWS-1, the next state is FILL if w<ROWS after update, else DONE.
- WRITE:
  - wr_en=1, wr_addr=w, wr_data=rd_data; then r++, w++.
  - Next state: SCAN, or FILL/DONE after row ROWS-1 (same rule as SCAN).
  - A copy therefore costs 2 cycles.
- FILL:
  - wr_en=1, wr_addr=w, wr_data=0, w++, one row per cycle.
  - Go to DONE after writing row ROWS-1.
- DONE: done=1, busy=1, clear_count=cnt; next cycle IDLE.
- Latency from the start edge to the done cycle is 1 + (#skipped rows) + (#in-place rows) + 2×(#copied rows) + (#filled rows).
  - #filled rows = clear_count.
- Boundaries:
  - full_rows=0: no writes; done after ROWS+1 cycles; clear_count=0.
  - All rows full: ROWS skips, ROWS zero writes; clear_count=ROWS.
  - Top row full: rows below stay in place; one FILL write of row ROWS-1.
- cnt never exceeds ROWS; CW bits suffice, so there is no wrap.
- wr_en is never asserted in IDLE, SCAN or DONE.
- rd_addr holds its last value outside SCAN.

Optional Feature:
- Macro: ROW_CLEAR_SCORE_EN.
- Defined:
  - Adds output `score_inc` (11 bits), registered on entering DONE and reset to 0.
  - Lookup on clear_count: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then full_rows=0, start → no wr_en for the whole run; done 23 cycles after the start edge; clear_count=0; busy high cycles 1–23.
- full_rows=22'h000001, board row k = k → done at cycle 45.
  - Rows 0..20 hold 1..21; row 21 = 0; clear_count=1; score_inc=40.
- full_rows bits 3 and 5 set → done at cycle 42.
  - Row3=old4, rows 4..19 = old 6..21, rows 20,21 = 0; clear_count=2; score_inc=100.
- full_rows=22'h3FFFFF → 22 zero writes, rows 0..21 = 0; done at cycle 45; clear_count=22; score_inc=1200.
- start pulses while busy → ignored; no change to mask, count or write sequence vs. a clean run.
- Reset asserted during WRITE → same cycle: wr_en=0, busy=0; next start runs a normal sequence.
